reg_writeback: RTL and testbench
================================

REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set write-queue entries (power of two, 2..16).
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 alu_valid / alu_addr / alu_data  input  1/4/16  ALU result write request: target register, value.
REQ-005 alu_ready  output  1  ALU request accepted this cycle.
REQ-006 mem_valid / mem_addr / mem_data  input  1/4/16  load-result write request.
REQ-007 mem_ready  output  1  load request accepted this cycle.
REQ-008 wb_stall  input  1  register-file write port unavailable this cycle.
REQ-009 w_en / addr_c / data_c  output  1/4/16  write port driving register file.
REQ-010 chk_addr_a / chk_addr_b / chk_addr_d  input  4 each  registers the decode stage is about to read.
REQ-011 busy_a / busy_b / busy_d  output  1 each  matching register has a pending queued write.

Function
REQ-012 Requests SHALL be held in a FIFO of DEPTH entries {addr, data}: 2-state pointers, wrap modulo DEPTH, occupancy count 0..DEPTH.
REQ-013 At most one enqueue per cycle; mem SHALL have fixed priority over alu when both valid.
REQ-014 mem_ready = mem_valid & !full; alu_ready = alu_valid & !mem_valid & !full; handshake completes when valid & ready at the clock edge.
REQ-015 Full SHALL block both sources even if a dequeue occurs the same cycle (no push-through-full).
REQ-016 w_en = !empty & !wb_stall; addr_c/data_c SHALL equal head entry when non-empty, 0 when empty.
REQ-017 Head SHALL be popped at the edge where w_en=1; latency request-accept edge N to w_en=1 is cycle N+1 minimum.
REQ-018 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-019 Writes SHALL retire in acceptance order; same-address entries all retire (last accepted wins in register file).
REQ-020 busy_x SHALL be 1 iff any occupied entry has addr == chk_addr_x, combinationally, including the head being written this cycle.
REQ-021 wb_stall SHALL freeze the queue head; enqueue SHALL continue while not full.

Reset
REQ-022 rst SHALL clear count and both pointers; queued entries discarded, no partial write issued.
REQ-023 During and in the cycle after reset: w_en=0, addr_c=0, data_c=0, alu_ready=0, mem_ready=0, busy_*=0.
REQ-024 Request valid during the rst cycle SHALL NOT be accepted.

Configuration
REQ-025 Macro REG_WRITEBACK_FORWARD_EN defined: outputs fwd_valid_a/b/d (1) and fwd_data_a/b/d (16) SHALL exist; fwd_valid_x = busy_x, fwd_data_x = data of the youngest matching entry, else 0.
REQ-026 Macro undefined: forwarding ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-027 alu_valid, alu_addr=3, alu_data=16'h1234, empty queue -> alu_ready=1; next cycle w_en=1, addr_c=3, data_c=16'h1234; then w_en=0.
REQ-028 mem (addr 5, 16'hAAAA) and alu (addr 6, 16'hBBBB) both valid -> mem_ready=1, alu_ready=0; writes retire 5 then 6.
REQ-029 wb_stall=1, push 4 requests (DEPTH=4) -> fifth sees ready=0; release stall -> 4 writes in order on consecutive cycles.
REQ-030 Queue holds addr 7, chk_addr_a=7, chk_addr_b=8 -> busy_a=1, busy_b=0; after retire busy_a=0.
REQ-031 Assert rst with 3 entries queued -> next cycle w_en=0, busy_*=0, no further writes.
REQ-032 With REG_WRITEBACK_FORWARD_EN: queue addr 2 data 16'h0011 then addr 2 data 16'h0022, stalled, chk_addr_d=2 -> fwd_valid_d=1, fwd_data_d=16'h0022.

Source files
------------

// File: rtl/reg_writeback.sv
// Register-file writeback queue: merges ALU and load results into one in-order write port with hazard lookup.
// Optional macro REG_WRITEBACK_FORWARD_EN adds per-read-port forwarding of the youngest queued value.
module reg_writeback #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [3:0]  alu_addr,
  input  logic [15:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [3:0]  mem_addr,
  input  logic [15:0] mem_data,
  output logic        mem_ready,
  input  logic        wb_stall,
  output logic        w_en,
  output logic [3:0]  addr_c,
  output logic [15:0] data_c,
  input  logic [3:0]  chk_addr_a,
  input  logic [3:0]  chk_addr_b,
  input  logic [3:0]  chk_addr_d,
  output logic        busy_a,
  output logic        busy_b,
  output logic        busy_d
`ifdef REG_WRITEBACK_FORWARD_EN
  ,
  output logic        fwd_valid_a,
  output logic        fwd_valid_b,
  output logic        fwd_valid_d,
  output logic [15:0] fwd_data_a,
  output logic [15:0] fwd_data_b,
  output logic [15:0] fwd_data_d
`endif
);

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 16;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;

  wb_entry_t        entries [DEPTH];
  wb_entry_t        push_entry;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             rst_d;
  logic             full;
  logic             empty;
  logic             gate;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] occ;

  // Acceptance is held off during reset and the cycle after it.
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign gate      = rst | rst_d;
  assign mem_ready = mem_valid & ~full & ~gate;
  assign alu_ready = alu_valid & ~mem_valid & ~full & ~gate;
  assign push      = mem_ready | alu_ready;
  assign w_en      = ~empty & ~wb_stall & ~rst;
  assign pop       = w_en;

  always_comb begin
    push_entry.addr = alu_addr;
    push_entry.data = alu_data;
    if (mem_valid) begin
      push_entry.addr = mem_addr;
      push_entry.data = mem_data;
    end
  end

  always_comb begin
    addr_c = '0;
    data_c = '0;
    if (!empty && !rst) begin
      addr_c = entries[rd_ptr].addr;
      data_c = entries[rd_ptr].data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      rst_d  <= 1'b1;
    end else begin
      rst_d <= 1'b0;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) entries[wr_ptr] <= push_entry;
  end

  // Slot is occupied when its distance from the head is below the occupancy count.
  always_comb begin
    occ = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      occ[i] = (CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr)) < count);
    end
  end

  always_comb begin
    busy_a = 1'b0;
    busy_b = 1'b0;
    busy_d = 1'b0;
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (occ[i] && entries[i].addr == chk_addr_a) busy_a = 1'b1;
        if (occ[i] && entries[i].addr == chk_addr_b) busy_b = 1'b1;
        if (occ[i] && entries[i].addr == chk_addr_d) busy_d = 1'b1;
      end
    end
  end

`ifdef REG_WRITEBACK_FORWARD_EN
  logic [PTR_W-1:0] age_idx;

  assign fwd_valid_a = busy_a;
  assign fwd_valid_b = busy_b;
  assign fwd_valid_d = busy_d;

  // Walk oldest to youngest so the last match is the most recent value.
  always_comb begin
    fwd_data_a = '0;
    fwd_data_b = '0;
    fwd_data_d = '0;
    age_idx    = rd_ptr;
    if (!rst) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        age_idx = rd_ptr + PTR_W'(k);
        if (CNT_W'(k) < count) begin
          if (entries[age_idx].addr == chk_addr_a) fwd_data_a = entries[age_idx].data;
          if (entries[age_idx].addr == chk_addr_b) fwd_data_b = entries[age_idx].data;
          if (entries[age_idx].addr == chk_addr_d) fwd_data_d = entries[age_idx].data;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Directed self-checking bench for reg_writeback (DEPTH=4).
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [3:0]  alu_addr;
  logic [15:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [3:0]  mem_addr;
  logic [15:0] mem_data;
  logic        mem_ready;
  logic        wb_stall;
  logic        w_en;
  logic [3:0]  addr_c;
  logic [15:0] data_c;
  logic [3:0]  chk_addr_a;
  logic [3:0]  chk_addr_b;
  logic [3:0]  chk_addr_d;
  logic        busy_a;
  logic        busy_b;
  logic        busy_d;
`ifdef REG_WRITEBACK_FORWARD_EN
  logic        fwd_valid_a;
  logic        fwd_valid_b;
  logic        fwd_valid_d;
  logic [15:0] fwd_data_a;
  logic [15:0] fwd_data_b;
  logic [15:0] fwd_data_d;
`endif

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  reg_writeback #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .wb_stall(wb_stall), .w_en(w_en), .addr_c(addr_c), .data_c(data_c),
    .chk_addr_a(chk_addr_a), .chk_addr_b(chk_addr_b), .chk_addr_d(chk_addr_d),
    .busy_a(busy_a), .busy_b(busy_b), .busy_d(busy_d)
`ifdef REG_WRITEBACK_FORWARD_EN
    ,
    .fwd_valid_a(fwd_valid_a), .fwd_valid_b(fwd_valid_b), .fwd_valid_d(fwd_valid_d),
    .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b), .fwd_data_d(fwd_data_d)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled off-edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push_alu(input logic [3:0] a, input logic [15:0] d, input string tag);
    alu_valid = 1'b1;
    alu_addr  = a;
    alu_data  = d;
    #1;
    chk(tag, 16'(alu_ready), 16'd1);
    cyc();
    alu_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wb_stall = 1'b0;
    alu_valid = 1'b1; alu_addr = 4'd9; alu_data = 16'h0005;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    chk_addr_a = 4'd0; chk_addr_b = 4'd0; chk_addr_d = 4'd0;

    // Reset: nothing accepted during or right after reset
    cyc();
    #1;
    chk("rst_alu_ready", 16'(alu_ready), 16'd0);
    chk("rst_w_en", 16'(w_en), 16'd0);
    chk("rst_addr_c", 16'(addr_c), 16'd0);
    chk("rst_data_c", data_c, 16'h0000);
    cyc();
    rst = 1'b0;
    #1;
    chk("post_rst_alu_ready", 16'(alu_ready), 16'd0);
    chk("post_rst_w_en", 16'(w_en), 16'd0);
    chk("post_rst_busy_a", 16'(busy_a), 16'd0);
    alu_valid = 1'b0;
    cyc();
    #1;
    chk("rst_req_not_taken", 16'(w_en), 16'd0);

    // Single ALU write, one-cycle latency
    push_alu(4'd3, 16'h1234, "alu_ready_single");
    #1;
    chk("single_w_en", 16'(w_en), 16'd1);
    chk("single_addr", 16'(addr_c), 16'd3);
    chk("single_data", data_c, 16'h1234);
    cyc();
    #1;
    chk("single_idle_w_en", 16'(w_en), 16'd0);
    chk("single_idle_data", data_c, 16'h0000);

    // mem has priority over alu
    mem_valid = 1'b1; mem_addr = 4'd5; mem_data = 16'hAAAA;
    alu_valid = 1'b1; alu_addr = 4'd6; alu_data = 16'hBBBB;
    #1;
    chk("prio_mem_ready", 16'(mem_ready), 16'd1);
    chk("prio_alu_ready", 16'(alu_ready), 16'd0);
    cyc();
    mem_valid = 1'b0;
    #1;
    chk("prio_alu_ready_next", 16'(alu_ready), 16'd1);
    chk("prio_first_addr", 16'(addr_c), 16'd5);
    chk("prio_first_data", data_c, 16'hAAAA);
    cyc();
    alu_valid = 1'b0;
    #1;
    chk("prio_second_w_en", 16'(w_en), 16'd1);
    chk("prio_second_addr", 16'(addr_c), 16'd6);
    chk("prio_second_data", data_c, 16'hBBBB);
    cyc();
    #1;
    chk("prio_drained", 16'(w_en), 16'd0);

    // Fill under stall, full blocks, then in-order drain
    wb_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      push_alu(4'(i), 16'hC000 | 16'(i), "fill_alu_ready");
      #1;
      chk("fill_stalled_w_en", 16'(w_en), 16'd0);
    end
    alu_valid = 1'b1; alu_addr = 4'd9; alu_data = 16'hDEAD;
    mem_valid = 1'b1; mem_addr = 4'd9; mem_data = 16'hBEEF;
    chk_addr_a = 4'd3; chk_addr_b = 4'd8; chk_addr_d = 4'd1;
    #1;
    chk("full_alu_ready", 16'(alu_ready), 16'd0);
    chk("full_mem_ready", 16'(mem_ready), 16'd0);
    chk("full_busy_a", 16'(busy_a), 16'd1);
    chk("full_busy_b", 16'(busy_b), 16'd0);
    chk("full_busy_d_head", 16'(busy_d), 16'd1);
    chk("full_head_frozen", 16'(addr_c), 16'd1);
    wb_stall = 1'b0;
    #1;
    chk("full_pop_w_en", 16'(w_en), 16'd1);
    chk("full_no_pushthrough_alu", 16'(alu_ready), 16'd0);
    chk("full_no_pushthrough_mem", 16'(mem_ready), 16'd0);
    cyc();
    alu_valid = 1'b0; mem_valid = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      #1;
      chk("drain_w_en", 16'(w_en), 16'd1);
      chk("drain_addr", 16'(addr_c), 16'(i));
      chk("drain_data", data_c, 16'hC000 | 16'(i));
      cyc();
    end
    #1;
    chk("drain_done_w_en", 16'(w_en), 16'd0);
    chk("drain_done_busy_a", 16'(busy_a), 16'd0);

    // Hazard lookup on a single queued write
    wb_stall = 1'b1;
    chk_addr_a = 4'd7; chk_addr_b = 4'd8; chk_addr_d = 4'd0;
    push_alu(4'd7, 16'h7777, "haz_alu_ready");
    #1;
    chk("haz_busy_a", 16'(busy_a), 16'd1);
    chk("haz_busy_b", 16'(busy_b), 16'd0);
    wb_stall = 1'b0;
    #1;
    chk("haz_busy_a_during_write", 16'(busy_a), 16'd1);
    chk("haz_write_addr", 16'(addr_c), 16'd7);
    cyc();
    #1;
    chk("haz_busy_a_retired", 16'(busy_a), 16'd0);

    // Reset with queued entries discards them
    wb_stall = 1'b1;
    chk_addr_a = 4'd10; chk_addr_b = 4'd11; chk_addr_d = 4'd12;
    for (int i = 10; i <= 12; i++) push_alu(4'(i), 16'(i), "rq_alu_ready");
    #1;
    chk("rq_busy_b", 16'(busy_b), 16'd1);
    chk("rq_busy_d", 16'(busy_d), 16'd1);
    rst = 1'b1; wb_stall = 1'b0;
    #1;
    chk("rq_in_rst_w_en", 16'(w_en), 16'd0);
    chk("rq_in_rst_busy_a", 16'(busy_a), 16'd0);
    cyc();
    rst = 1'b0;
    #1;
    chk("rq_after_w_en", 16'(w_en), 16'd0);
    chk("rq_after_busy_a", 16'(busy_a), 16'd0);
    chk("rq_after_busy_b", 16'(busy_b), 16'd0);
    chk("rq_after_busy_d", 16'(busy_d), 16'd0);
    chk("rq_after_addr_c", 16'(addr_c), 16'd0);
    cyc();
    #1;
    chk("rq_no_more_writes", 16'(w_en), 16'd0);

`ifdef REG_WRITEBACK_FORWARD_EN
    // Forwarding picks the youngest matching entry
    wb_stall = 1'b1;
    chk_addr_a = 4'd2; chk_addr_b = 4'd9; chk_addr_d = 4'd2;
    push_alu(4'd2, 16'h0011, "fwd_push1");
    push_alu(4'd2, 16'h0022, "fwd_push2");
    #1;
    chk("fwd_valid_d", 16'(fwd_valid_d), 16'd1);
    chk("fwd_data_d", fwd_data_d, 16'h0022);
    chk("fwd_data_a", fwd_data_a, 16'h0022);
    chk("fwd_valid_b", 16'(fwd_valid_b), 16'd0);
    chk("fwd_data_b", fwd_data_b, 16'h0000);
    wb_stall = 1'b0;
    cyc();
    cyc();
    #1;
    chk("fwd_drained", 16'(fwd_valid_d), 16'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
